// File: rtl/spram_wait_pkg.sv
// spram_wait_pkg
//   Shared definitions for the burst-throttled single-port RAM block:
//   the RUN/WAIT state type, counter width and default parameter values.
//   Imported by spram_wait_burst and fifo_ndepth.

package spram_wait_pkg;

   // Throttle state: RUN lets queued reads issue, WAIT holds them back.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Burst and wait counters are 8 bits, so BURST and WAIT are limited to 1..255.
   localparam int CNT_W = 8;

   localparam int DEF_DW    = 8;
   localparam int DEF_AW    = 8;
   localparam int DEF_BURST = 8;
   localparam int DEF_WAIT  = 4;
   localparam int DEF_QD    = 2;

endpackage

// File: rtl/fifo_ndepth.sv
// fifo_ndepth
//   Small synchronous FIFO used as the read-request queue.
//   Parameters: W data width, D depth (power of two, >= 2).
//   Ports:
//     clk, rst     clock, synchronous active-high reset (flushes the queue)
//     push, din    write an entry (caller guarantees !full)
//     pop          drop the head entry (caller guarantees !empty)
//     dout         current head entry (valid when !empty)
//     full, empty  occupancy flags, combinational from the pointers
//   A push and pop in the same cycle leave the occupancy unchanged.

module fifo_ndepth
   import spram_wait_pkg::*;
#(
   parameter int W = DEF_AW,
   parameter int D = DEF_QD
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int PW = $clog2(D);
   localparam logic [PW:0] PTR_ONE = 1;

   logic [W-1:0] slots [D];

   // One extra pointer bit distinguishes full from empty when the
   // index bits are equal.
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) slots[wr_ptr[PW-1:0]] <= din;
   end

   assign dout  = slots[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                  (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/spram_wait_burst.sv
// spram_wait_burst
//   2^AW x DW RAM with an always-accepted write port and a queued read port
//   that is throttled: after BURST issued reads the block sits in WAIT for
//   WAIT cycles before issuing again.
//   Parameters: DW data width, AW address width, BURST reads per burst,
//               WAIT wait-window length, QD request queue depth.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     wr_en/wr_addr/wr_data  write port, never throttled
//     rd_valid/rd_ready/rd_addr  read request; accepted when both high
//     rd_dvalid/rd_data   one-cycle data pulse per issued read; rd_data holds
//     stall               high while in WAIT (this is the FSM state itself)
//   Handshake: a request transfers on a rising edge where rd_valid and
//   rd_ready are both high; rd_ready is "queue not full" and does not depend
//   on rd_valid, so the requester may hold rd_valid until it sees rd_ready.
//   Build option: define SPRAM_WAIT_WRFWD_EN to return wr_data for a read
//   issued in the same cycle as a write to the same address; otherwise such
//   a read returns the old contents.

module spram_wait_burst
   import spram_wait_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int BURST = DEF_BURST,
   parameter int WAIT  = DEF_WAIT,
   parameter int QD    = DEF_QD
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_valid,
   output logic          rd_ready,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_dvalid,
   output logic [DW-1:0] rd_data,
   output logic          stall
);

   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = 1;

   logic [DW-1:0] mem [2**AW];

   logic          q_full;
   logic          q_empty;
   logic [AW-1:0] q_head;
   logic          issue;
   logic [DW-1:0] rd_word;

   state_t           state, state_nx;
   logic [CNT_W-1:0] burst_cnt, burst_nx;
   logic [CNT_W-1:0] wait_cnt, wait_nx;

   assign rd_ready = !q_full;
   assign issue    = !q_empty && (state == ST_RUN);
   assign stall    = (state == ST_WAIT);

   fifo_ndepth #(
      .W (AW),
      .D (QD)
   ) u_req_q (
      .clk   (clk),
      .rst   (rst),
      .push  (rd_valid && rd_ready),
      .pop   (issue),
      .din   (rd_addr),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // The array read happens at the issue edge, before that edge's write
   // lands, so a same-cycle write is only seen through the bypass.
`ifdef SPRAM_WAIT_WRFWD_EN
   assign rd_word = (wr_en && (wr_addr == q_head)) ? wr_data : mem[q_head];
`else
   assign rd_word = mem[q_head];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dvalid <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_dvalid <= issue;
         if (issue) rd_data <= rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RUN;
         burst_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         state     <= state_nx;
         burst_cnt <= burst_nx;
         wait_cnt  <= wait_nx;
      end
   end

   always_comb begin
      state_nx = state;
      burst_nx = burst_cnt;
      wait_nx  = wait_cnt;
      case (state)
         ST_RUN: begin
            // The burst count only moves on issued reads; idle cycles hold it.
            if (issue) begin
               if (burst_cnt == BURST_LAST) begin
                  burst_nx = '0;
                  state_nx = ST_WAIT;
               end else begin
                  burst_nx = burst_cnt + CNT_ONE;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               wait_nx  = '0;
               state_nx = ST_RUN;
            end else begin
               wait_nx = wait_cnt + CNT_ONE;
            end
         end
         default: state_nx = ST_RUN;
      endcase
   end

endmodule

// File: tb/tb_spram_wait_burst.sv
// tb_spram_wait_burst
//   Directed and randomized bench for spram_wait_burst. A second instance
//   with BURST=1, WAIT=1 shares clk/rst to cover the alternating case.
//   Expected values come from a queue-based model of the read throttle.

module tb_spram_wait_burst;

   localparam int DW     = 8;
   localparam int AW     = 8;
   localparam int BURST  = 8;
   localparam int WAIT_C = 4;
   localparam int QD     = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_addr;
   logic          rd_dvalid;
   logic [DW-1:0] rd_data;
   logic          stall;

   logic          rd_valid1;
   logic          rd_ready1;
   logic [AW-1:0] rd_addr1;
   logic          rd_dvalid1;
   logic [DW-1:0] rd_data1;
   logic          stall1;

   always #5 clk = ~clk;

   spram_wait_burst #(
      .DW(DW), .AW(AW), .BURST(BURST), .WAIT(WAIT_C), .QD(QD)
   ) u_dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_dvalid(rd_dvalid), .rd_data(rd_data), .stall(stall)
   );

   spram_wait_burst #(
      .DW(DW), .AW(AW), .BURST(1), .WAIT(1), .QD(QD)
   ) u_dut1 (
      .clk(clk), .rst(rst),
      .wr_en(1'b0), .wr_addr('0), .wr_data('0),
      .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rd_addr(rd_addr1),
      .rd_dvalid(rd_dvalid1), .rd_data(rd_data1), .stall(stall1)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] m_mem [256];
   logic [AW-1:0] m_q[$];
   int            m_burst = 0;
   int            m_wait_left = 0;
   logic [DW-1:0] m_last = '0;
   int            m1_occ = 0;
   int            m1_wait_left = 0;

   // Observation records: 1 = data pulse, 2 = stalled cycle
   int            ev_q[$];
   logic [DW-1:0] got_q[$];
   int            s1_cnt;
   bit            dut_acc;
   bit            dut_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pulses_before_stall();
      int n = 0;
      foreach (ev_q[i]) begin
         if (ev_q[i] == 2) return n;
         n++;
      end
      return n;
   endfunction

   function automatic int stalls_after_pulse(input int k);
      int p = 0;
      int s = 0;
      foreach (ev_q[i]) begin
         if (ev_q[i] == 1) begin
            p++;
            if (p > k) return s;
         end else if (p == k) begin
            s++;
         end
      end
      return s;
   endfunction

   // One clock cycle: drive, check combinational outputs, advance model,
   // check registered outputs after the edge.
   task automatic cycle(input bit r, input bit we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input bit rv,
                        input logic [AW-1:0] ra, output bit acc);
      bit            exp_rdy, exp_stl, iss, exp_rdy1, exp_stl1, iss1;
      logic [DW-1:0] exp_d;
      logic [AW-1:0] a;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      rd_valid = rv; rd_addr = ra;
      rd_addr1 = AW'($urandom_range(0, 255));
      #1;
      exp_rdy  = (m_q.size() < QD);
      exp_stl  = (m_wait_left != 0);
      exp_rdy1 = (m1_occ < QD);
      exp_stl1 = (m1_wait_left != 0);
      chk("rd_ready", rd_ready, exp_rdy);
      chk("stall", stall, exp_stl);
      chk("rd_ready1", rd_ready1, exp_rdy1);
      chk("stall1", stall1, exp_stl1);
      dut_rdy = rd_ready;
      dut_acc = rd_valid && rd_ready;
      if (stall) ev_q.push_back(2);
      if (stall1) s1_cnt++;

      acc   = rv && exp_rdy;
      iss   = !exp_stl && (m_q.size() != 0);
      exp_d = m_last;
      if (iss) begin
         a = m_q.pop_front();
`ifdef SPRAM_WAIT_WRFWD_EN
         exp_d = (we && wa == a) ? wd : m_mem[a];
`else
         exp_d = m_mem[a];
`endif
         m_burst++;
         if (m_burst == BURST) begin
            m_burst = 0;
            m_wait_left = WAIT_C;
         end
      end else if (exp_stl) begin
         m_wait_left--;
      end
      if (acc) m_q.push_back(ra);
      if (we) m_mem[wa] = wd;

      iss1 = !exp_stl1 && (m1_occ != 0);
      if (iss1) begin
         m1_occ--;
         m1_wait_left = 1;
      end else if (exp_stl1) begin
         m1_wait_left--;
      end
      if (rd_valid1 && exp_rdy1) m1_occ++;

      if (r) begin
         m_q.delete();
         m_burst = 0; m_wait_left = 0;
         iss = 1'b0; exp_d = '0;
         m1_occ = 0; m1_wait_left = 0; iss1 = 1'b0;
      end

      @(posedge clk); #1;
      chk("rd_dvalid", rd_dvalid, iss);
      chk("rd_data", rd_data, exp_d);
      chk("rd_dvalid1", rd_dvalid1, iss1);
      m_last = exp_d;
      if (rd_dvalid) begin
         ev_q.push_back(1);
         got_q.push_back(rd_data);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, acc);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit acc;
      cycle(0, 1, a, d, 0, '0, acc);
   endtask

   task automatic push(input logic [AW-1:0] a);
      bit acc;
      int n = 0;
      do begin
         cycle(0, 0, '0, '0, 1, a, acc);
         n++;
      end while (!acc && n < 32);
      if (!acc) chk("push_timeout", 32'(n), 32'(0));
   endtask

   task automatic drain();
      int n = 0;
      while ((m_q.size() != 0 || m_wait_left != 0) && n < 64) begin
         idle(1);
         n++;
      end
      idle(1);
      if (n >= 64) chk("drain_timeout", 32'(n), 32'(0));
   endtask

   task automatic do_reset();
      bit acc;
      cycle(1, 0, '0, '0, 0, '0, acc);
   endtask

   initial begin
      bit acc;
      int k;
      int acc_cnt;
      logic [DW-1:0] exp_fwd;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; rd_valid1 = 1'b0; rd_addr1 = '0;
      s1_cnt = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_dvalid", rd_dvalid, 0);
      chk("reset_data", rd_data, 0);
      chk("reset_stall", stall, 0);
      chk("reset_ready", rd_ready, 1);

      // Fill and read back 16 words: two bursts around one wait window.
      for (int i = 0; i < 16; i++) wr(AW'(i), DW'(i + 'h10));
      ev_q.delete(); got_q.delete();
      for (int i = 0; i < 16; i++) push(AW'(i));
      drain();
      chk("burst_pulses", got_q.size(), 16);
      for (int i = 0; i < 16 && i < got_q.size(); i++)
         chk("burst_data", got_q[i], 'h10 + i);
      chk("burst_first_run", pulses_before_stall(), 8);
      chk("burst_wait_len", stalls_after_pulse(8), 4);

      // Enter WAIT with an empty queue, then hold rd_valid high.
      for (int i = 0; i < 8; i++) begin
         push(AW'(i));
         idle(1);
      end
      acc_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, '0, '0, 1, 8'd3, acc);
         if (dut_acc) acc_cnt++;
      end
      chk("wait_accepts", acc_cnt, QD);
      cycle(0, 0, '0, '0, 1, 8'd3, acc);
      chk("ready_first_run", dut_rdy, 0);
      cycle(0, 0, '0, '0, 1, 8'd3, acc);
      chk("ready_after_issue", dut_rdy, 1);
      drain();

      // Same-cycle write and read of address 5.
      push(8'd5);
      got_q.delete();
      wr(8'd5, 8'hAA);
`ifdef SPRAM_WAIT_WRFWD_EN
      exp_fwd = 8'hAA;
`else
      exp_fwd = 8'h15;
`endif
      chk("fwd_count", got_q.size(), 1);
      if (got_q.size() != 0) chk("fwd_data", got_q[0], exp_fwd);
      drain();

      // Reset mid-burst with a read in flight.
      k = 0;
      while (m_burst != 5 && k < 40) begin
         push(AW'(k % 16));
         idle(1);
         k++;
      end
      chk("mid_burst_count", m_burst, 5);
      cycle(0, 0, '0, '0, 1, 8'd7, acc);
      ev_q.delete(); got_q.delete();
      cycle(1, 0, '0, '0, 1, 8'd8, acc);
      idle(3);
      chk("rst_no_dvalid", got_q.size(), 0);
      chk("rst_stall", stall, 0);
      chk("rst_ready", rd_ready, 1);
      for (int i = 0; i < 14; i++) cycle(0, 0, '0, '0, 1, AW'(i), acc);
      chk("rst_full_burst", pulses_before_stall(), 8);
      drain();

      // Burst count holds across idle cycles.
      do_reset();
      ev_q.delete();
      for (int i = 0; i < 3; i++) begin
         push(AW'(i));
         idle(1);
      end
      idle(10);
      chk("idle_no_stall", pulses_before_stall(), 3);
      for (int i = 0; i < 5; i++) push(AW'(i + 3));
      drain();
      chk("hold_burst", pulses_before_stall(), 8);

      // Randomized traffic, occasional reset.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 15)), DW'($urandom),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), acc);
      end
      drain();

      // BURST=1, WAIT=1 instance under continuous requests.
      rd_valid1 = 1'b1;
      idle(2);
      s1_cnt = 0;
      idle(10);
      chk("alt_stall_cycles", s1_cnt, 5);
      rd_valid1 = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/spram_wait_burst.md
SPRAM_WAIT_BURST -- requirements
Module: spram_wait_burst

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 8, address width in bits; memory depth is 2^AW words.
REQ-003 SHALL have parameter BURST, default 8, number of reads issued before a wait window (legal range 1..255).
REQ-004 SHALL have parameter WAIT, default 4, length of the wait window in cycles (legal range 1..255).
REQ-005 SHALL have parameter QD, default 2, read-request queue depth (power of two, at least 2).
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 wr_en  in  1  write strobe; always accepted, never throttled.
REQ-009 wr_addr  in  AW  write address.
REQ-010 wr_data  in  DW  write data.
REQ-011 rd_valid  in  1  read request valid.
REQ-012 rd_ready  out  1  read request accepted when rd_valid and rd_ready are both high.
REQ-013 rd_addr  in  AW  read request address.
REQ-014 rd_dvalid  out  1  read data valid, single-cycle pulse per issued read.
REQ-015 rd_data  out  DW  read data, qualified by rd_dvalid.
REQ-016 stall  out  1  high while the block is in the WAIT state.

Function
REQ-017 SHALL hold a 2^AW x DW array; a write updates mem[wr_addr] at the clock edge where wr_en is high.
REQ-018 SHALL buffer accepted read addresses in a QD-entry FIFO, in order; rd_ready = FIFO not full (combinational).
REQ-019 SHALL issue the FIFO head when the FIFO is non-empty and state is RUN; an issue pops the head.
REQ-020 SHALL return data one cycle after issue: rd_dvalid=1 and rd_data=mem[addr] at edge N+1 for an issue at edge N.
REQ-021 SHALL hold rd_data at its last value when rd_dvalid=0.
REQ-022 SHALL have states RUN and WAIT; a burst counter counts issued reads in RUN and holds on cycles with no issue.
REQ-023 In RUN, an issue with burst count = BURST-1 SHALL clear the burst count and enter WAIT on the next cycle.
REQ-024 In WAIT, the block SHALL issue nothing and SHALL increment a wait counter; at count WAIT-1 it SHALL clear the counter and return to RUN.
REQ-025 Requests SHALL continue to be accepted into the FIFO during WAIT while it is not full.
REQ-026 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged; a push when full is impossible because rd_ready=0.
REQ-027 Read and write to the same address in the same cycle SHALL return the old data unless REQ-032 applies.
REQ-028 Counters SHALL be 8 bits wide and SHALL never exceed BURST-1 or WAIT-1.

Reset
REQ-029 rst SHALL flush the FIFO, set state RUN, clear both counters, and set rd_dvalid=0, rd_data=0, stall=0; rd_ready is therefore 1 in the cycle after reset.
REQ-030 rst asserted mid-burst or mid-wait SHALL discard all pending reads; the in-flight read SHALL produce no rd_dvalid.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 With SPRAM_WAIT_WRFWD_EN defined, a read issued in the same cycle as a write to the same address SHALL return wr_data; without it, the read SHALL return the old contents.

Structure
REQ-033 Package spram_wait_pkg SHALL hold the RUN/WAIT state type and the default parameter constants.
REQ-034 The request queue SHALL be a sub-module fifo_ndepth, parameterised by width AW and depth QD.

Verification
REQ-035 Write mem[i]=i+0x10 for i=0..15, then request reads 0..15 back-to-back -> 8 rd_dvalid pulses, stall high for 4 cycles, then 8 more pulses; data is 0x10..0x1F in order.
REQ-036 With QD=2, hold rd_valid high during WAIT -> rd_ready drops after 2 accepts and rises after the first issue in RUN.
REQ-037 Write addr 5 = 0xAA and issue a read of addr 5 in the same cycle -> returns 0xAA with the macro defined, the old value without it.
REQ-038 Assert rst at burst count 5 with 2 requests queued -> no rd_dvalid afterwards, stall=0, rd_ready=1, and the next burst allows a full 8 reads.
REQ-039 Issue 3 reads, idle 10 cycles, then issue 5 more reads -> stall asserts after the 8th issued read (the count holds while idle).
REQ-040 BURST=1, WAIT=1 -> issue and stall alternate every cycle under continuous requests.
